// File: rtl/rgmii_rx_speed_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_rx_speed_adapter_pkg
// Description : Shared speed encodings, receive FSM states, preamble/SFD
//               nibbles and in-band status bit positions for the RGMII
//               receive back end.
// Revision    : 1.0 - initial release
// ============================================================================
package rgmii_rx_speed_adapter_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  // In-band status fields carried on rxd_rise during inter-frame gaps
  localparam int ST_LINK_BIT = 0;
  localparam int ST_SPD_LSB  = 1;
  localparam int ST_SPD_MSB  = 2;
  localparam int ST_DPX_BIT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_LO       = 3'd2,
    ST_HI       = 3'd3,
    ST_DRAIN    = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/rgmii_rx_speed_adapter_inband_status.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_inband_status
// Description : Decodes RGMII in-band link status from idle-gap samples and
//               updates the status outputs once a value has been seen on
//               STATUS_STABLE consecutive idle cycles. Used only when
//               RGMII_INBAND_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rgmii_inband_status
  import rgmii_rx_speed_adapter_pkg::*;
#(
  parameter int STATUS_STABLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [3:0] i_rxd,
  output logic       o_link_up,
  output logic [1:0] o_link_speed,
  output logic       o_link_duplex
);

  localparam int SC_W = $clog2(STATUS_STABLE + 1);
  localparam logic [SC_W-1:0] C_STABLE = SC_W'(STATUS_STABLE);

  logic [3:0]      r_cand;
  logic [SC_W-1:0] r_stab;
  logic [SC_W-1:0] w_stab_nxt;

  // Run length of the current candidate; any frame activity clears it
  always_comb begin
    w_stab_nxt = '0;
    if (i_valid) begin
      if (i_rxd != r_cand)
        w_stab_nxt = SC_W'(1);
      else if (r_stab != C_STABLE)
        w_stab_nxt = r_stab + SC_W'(1);
      else
        w_stab_nxt = r_stab;
    end
  end

  // Track the candidate and commit it once it has been stable long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand        <= 4'h0;
      r_stab        <= '0;
      o_link_up     <= 1'b0;
      o_link_speed  <= 2'b00;
      o_link_duplex <= 1'b0;
    end else begin
      r_stab <= w_stab_nxt;
      if (i_valid)
        r_cand <= i_rxd;
      if (i_valid && (w_stab_nxt == C_STABLE)) begin
        o_link_up     <= i_rxd[ST_LINK_BIT];
        o_link_speed  <= i_rxd[ST_SPD_MSB:ST_SPD_LSB];
        o_link_duplex <= i_rxd[ST_DPX_BIT];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgmii_rx_speed_adapter.sv
`default_nettype none
// ============================================================================
// Module      : rgmii_rx_speed_adapter
// Description : RGMII receive DDR samples to GMII byte stream with byte
//               strobe at 1000/100/10 Mb/s, SFD alignment in nibble mode,
//               max-length truncation and saturating frame/error counters.
//               Optional in-band status decode: RGMII_INBAND_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rgmii_rx_speed_adapter
  import rgmii_rx_speed_adapter_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1522,
  parameter int CNT_W         = 16,
  parameter int STATUS_STABLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_speed,
  input  logic [3:0]       i_rxd_rise,
  input  logic [3:0]       i_rxd_fall,
  input  logic             i_ctl_rise,
  input  logic             i_ctl_fall,
  output logic [7:0]       o_gmii_rxd,
  output logic             o_gmii_rx_ce,
  output logic             o_gmii_rx_dv,
  output logic             o_gmii_rx_er,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_link_up,
  output logic [1:0]       o_link_speed,
  output logic             o_link_duplex
);

  localparam int BC_W = $clog2(MAX_FRAME_LEN + 2);
  localparam logic [BC_W-1:0] C_LIM  = BC_W'(MAX_FRAME_LEN);
  localparam logic [BC_W-1:0] C_OVER = BC_W'(MAX_FRAME_LEN + 1);

  rx_state_t       r_state;
  logic [1:0]      r_speed;
  logic [3:0]      r_lo_nib;
  logic            r_lo_er;
  logic            r_bad_pre;
  logic            r_frm_err;
  logic            r_gig_frame;
  logic [BC_W-1:0] r_byte_cnt;

  logic w_gig, w_er_s, w_at_lim, w_over, w_end, w_end_err;

  assign w_gig    = (r_speed == SPD_1000) || (r_speed == 2'b11);
  assign w_er_s   = i_ctl_rise ^ i_ctl_fall;
  assign w_at_lim = (r_byte_cnt == C_LIM);
  assign w_over   = (r_byte_cnt == C_OVER);

  // A frame ends when RX_DV drops during gigabit data or nibble data phases;
  // an odd trailing nibble always marks the frame as errored
  assign w_end     = !i_ctl_rise &&
                     (((r_state == ST_IDLE) && w_gig && r_gig_frame) ||
                      (r_state == ST_LO) || (r_state == ST_HI));
  assign w_end_err = r_frm_err || (r_state == ST_HI);

  // Receive datapath: gigabit byte path in IDLE, nibble assembly FSM otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_speed      <= SPD_1000;
      r_lo_nib     <= 4'h0;
      r_lo_er      <= 1'b0;
      r_bad_pre    <= 1'b0;
      r_frm_err    <= 1'b0;
      r_gig_frame  <= 1'b0;
      r_byte_cnt   <= '0;
      o_gmii_rxd   <= 8'h00;
      o_gmii_rx_ce <= 1'b0;
      o_gmii_rx_dv <= 1'b0;
      o_gmii_rx_er <= 1'b0;
    end else begin
      o_gmii_rx_ce <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Speed only changes between frames
          if (!i_ctl_rise)
            r_speed <= i_speed;
          if (w_gig) begin
            o_gmii_rxd   <= {i_rxd_fall, i_rxd_rise};
            o_gmii_rx_dv <= i_ctl_rise;
            if (i_ctl_rise) begin
              r_gig_frame <= 1'b1;
              if (!w_over) begin
                o_gmii_rx_ce <= 1'b1;
                o_gmii_rx_er <= w_er_s | w_at_lim;
                r_byte_cnt   <= r_byte_cnt + BC_W'(1);
                r_frm_err    <= r_frm_err | w_er_s | w_at_lim;
              end
            end else begin
              o_gmii_rx_ce <= 1'b1;
              o_gmii_rx_er <= w_er_s;
              r_gig_frame  <= 1'b0;
              r_byte_cnt   <= '0;
              r_frm_err    <= 1'b0;
            end
          end else begin
            o_gmii_rx_dv <= 1'b0;
            o_gmii_rx_er <= 1'b0;
            if (i_ctl_rise) begin
              r_state    <= ST_PREAMBLE;
              r_bad_pre  <= 1'b0;
              r_byte_cnt <= '0;
              r_frm_err  <= 1'b0;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!i_ctl_rise) begin
            r_state <= ST_IDLE;
          end else if (i_rxd_rise == SFD_NIB) begin
            r_state <= ST_LO;
          end else if (i_rxd_rise != PREAMBLE_NIB) begin
            // Corrupt preamble: realign here and flag the first byte
            r_state   <= ST_LO;
            r_bad_pre <= 1'b1;
            r_frm_err <= 1'b1;
          end
        end
        ST_LO: begin
          if (!i_ctl_rise) begin
            r_state      <= ST_DRAIN;
            o_gmii_rx_dv <= 1'b0;
          end else begin
            r_lo_nib  <= i_rxd_rise;
            r_lo_er   <= w_er_s | r_bad_pre;
            r_bad_pre <= 1'b0;
            r_state   <= ST_HI;
          end
        end
        ST_HI: begin
          o_gmii_rx_dv <= 1'b1;
          o_gmii_rx_ce <= !w_over;
          if (!i_ctl_rise) begin
            // Odd nibble count: flush the orphan low nibble as an error byte
            o_gmii_rxd   <= {4'h0, r_lo_nib};
            o_gmii_rx_er <= 1'b1;
            r_state      <= ST_DRAIN;
          end else begin
            o_gmii_rxd   <= {i_rxd_rise, r_lo_nib};
            o_gmii_rx_er <= r_lo_er | w_er_s | w_at_lim;
            r_state      <= ST_LO;
            if (!w_over) begin
              r_byte_cnt <= r_byte_cnt + BC_W'(1);
              r_frm_err  <= r_frm_err | r_lo_er | w_er_s | w_at_lim;
            end
          end
        end
        ST_DRAIN: begin
          o_gmii_rx_dv <= 1'b0;
          o_gmii_rx_er <= 1'b0;
          r_frm_err    <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating frame and errored-frame counters, updated at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else if (w_end) begin
      if (o_frame_cnt != '1)
        o_frame_cnt <= o_frame_cnt + CNT_W'(1);
      if (w_end_err && (o_err_cnt != '1))
        o_err_cnt <= o_err_cnt + CNT_W'(1);
    end
  end

`ifdef RGMII_INBAND_STATUS_EN
  logic w_status_valid;
  assign w_status_valid = !i_ctl_rise && !i_ctl_fall;

  rgmii_inband_status #(
    .STATUS_STABLE (STATUS_STABLE)
  ) u_inband_status (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (w_status_valid),
    .i_rxd         (i_rxd_rise),
    .o_link_up     (o_link_up),
    .o_link_speed  (o_link_speed),
    .o_link_duplex (o_link_duplex)
  );
`else
  assign o_link_up     = 1'b1;
  assign o_link_speed  = i_speed;
  assign o_link_duplex = 1'b1;

  logic w_unused_stable;
  assign w_unused_stable = (STATUS_STABLE != 0);
`endif

endmodule
`default_nettype wire
